// File: rtl/axi_pkg.sv
// Shared types for the AXI slave memory: FSM state encodings and response codes.
package axi_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Any beat whose WLAST disagreed with its position turns the burst into SLVERR.
  function automatic logic [1:0] bresp_for(input logic wlast_err);
    return wlast_err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// Simple dual-port word array: byte-enable write port, registered read-first read port.
module axi_slave_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AWIDTH = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [MEM_AWIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [MEM_AWIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int DEPTH = 1 << MEM_AWIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  always_comb begin
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read samples mem_q before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) begin
          mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent write and read FSMs over a simple dual-port RAM,
// INCR full-width bursts only, one outstanding transaction per direction.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AWIDTH = 10,
  parameter int ID_WIDTH   = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [31:0]             S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [31:0]             S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [MEM_AWIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            awlen_q, awlen_d, wcnt_q, wcnt_d;
  logic                  werr_q, werr_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_en_s, wbeat_last_s, wlast_bad_s;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [MEM_AWIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            arlen_q, arlen_d, rcnt_q, rcnt_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                  rd_en_s;

  // Size, burst type and address bits outside the word index are deliberately ignored.
  logic unused_s;
  assign unused_s = ^{S_AXI_AWADDR[31:MEM_AWIDTH+4], S_AXI_AWADDR[3:0], S_AXI_AWSIZE, S_AXI_AWBURST,
                      S_AXI_ARADDR[31:MEM_AWIDTH+4], S_AXI_ARADDR[3:0], S_AXI_ARSIZE, S_AXI_ARBURST};

  always_comb begin
    w_state_d    = w_state_q;
    awid_d       = awid_q;
    waddr_d      = waddr_q;
    awlen_d      = awlen_q;
    wcnt_d       = wcnt_q;
    werr_d       = werr_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    wr_en_s      = 1'b0;
    wbeat_last_s = (wcnt_q == awlen_q);
    wlast_bad_s  = (S_AXI_WLAST != wbeat_last_s);
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (S_AXI_AWVALID && awready_q) begin
          awid_d    = S_AXI_AWID;
          waddr_d   = S_AXI_AWADDR[MEM_AWIDTH+3:4];
          awlen_d   = S_AXI_AWLEN;
          wcnt_d    = 8'd0;
          werr_d    = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          wr_en_s = ARESETN;
          waddr_d = waddr_q + MEM_AWIDTH'(1);
          wcnt_d  = wcnt_q + 8'd1;
          werr_d  = werr_q | wlast_bad_s;
          if (wbeat_last_s) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = bresp_for(werr_q | wlast_bad_s);
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      awid_q    <= {ID_WIDTH{1'b0}};
      waddr_q   <= {MEM_AWIDTH{1'b0}};
      awlen_q   <= 8'd0;
      wcnt_q    <= 8'd0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      awlen_q   <= awlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Each beat costs one fetch cycle plus one data cycle; RDATA is the RAM's own register.
  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    raddr_d   = raddr_q;
    arlen_d   = arlen_q;
    rcnt_d    = rcnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rd_en_s   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          arid_d    = S_AXI_ARID;
          raddr_d   = S_AXI_ARADDR[MEM_AWIDTH+3:4];
          arlen_d   = S_AXI_ARLEN;
          rcnt_d    = 8'd0;
          arready_d = 1'b0;
          r_state_d = R_FETCH;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_FETCH: begin
        rd_en_s   = 1'b1;
        rvalid_d  = 1'b1;
        rlast_d   = (rcnt_q == arlen_q);
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (S_AXI_RREADY && rvalid_q) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            raddr_d   = raddr_q + MEM_AWIDTH'(1);
            rcnt_d    = rcnt_q + 8'd1;
            r_state_d = R_FETCH;
          end
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      arid_q    <= {ID_WIDTH{1'b0}};
      raddr_q   <= {MEM_AWIDTH{1'b0}};
      arlen_q   <= 8'd0;
      rcnt_q    <= 8'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      raddr_q   <= raddr_d;
      arlen_q   <= arlen_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  axi_slave_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AWIDTH(MEM_AWIDTH)
  ) u_ram (
    .clk    (ACLK),
    .wr_en  (wr_en_s),
    .wr_addr(waddr_q),
    .wr_data(S_AXI_WDATA),
    .wr_strb(S_AXI_WSTRB),
    .rd_en  (rd_en_s),
    .rd_addr(raddr_q),
    .rd_data(S_AXI_RDATA)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BID     = awid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RID     = arid_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: a word-array reference model predicts B and R
// responses at issue time; a negedge monitor pops and compares on each handshake.
module tb_axi_slave_mem;

  localparam int DW    = 128;
  localparam int AW    = 10;
  localparam int IW    = 1;
  localparam int DEPTH = 1 << AW;

  logic          aclk, aresetn;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [31:0]   awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  axi_slave_mem #(.DATA_WIDTH(DW), .MEM_AWIDTH(AW), .ID_WIDTH(IW)) dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic last; } rexp_t;

  bexp_t b_q[$];
  rexp_t r_q[$];
  logic [DW-1:0]   model_mem [DEPTH];
  logic [DW-1:0]   wd [16];
  logic [DW/8-1:0] ws [16];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  rand_rdy = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake/response within budget", name);
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Monitor: a handshake seen at negedge completes on the next rising edge.
  initial begin
    bexp_t be;
    rexp_t re;
    forever begin
      @(negedge aclk);
      if (aresetn && bvalid && bready) begin
        if (b_q.size() == 0) begin
          fail_now("b_unexpected");
        end else begin
          be = b_q.pop_front();
          check("bid", DW'(bid), DW'(be.id));
          check("bresp", DW'(bresp), DW'(be.resp));
        end
      end
      if (aresetn && rvalid && rready) begin
        if (r_q.size() == 0) begin
          fail_now("r_unexpected");
        end else begin
          re = r_q.pop_front();
          check("rid", DW'(rid), DW'(re.id));
          check("rdata", rdata, re.data);
          check("rlast", DW'(rlast), DW'(re.last));
          check("rresp", DW'(rresp), DW'(2'b00));
        end
      end
    end
  end

  task automatic handshake(input int ch, output bit ok);
    bit rdy;
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      @(negedge aclk);
      case (ch)
        0:       rdy = awready;
        1:       rdy = wready;
        default: rdy = arready;
      endcase
      cyc();
      n++;
      ok = rdy;
    end
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    while (b_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    if (b_q.size() != 0) begin
      fail_now("b_drain");
      b_q.delete();
    end
  endtask

  task automatic drain_r();
    int n;
    n = 0;
    while (r_q.size() != 0 && n < 400) begin
      rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      n++;
    end
    rready = 1'b1;
    if (r_q.size() != 0) begin
      fail_now("r_drain");
      r_q.delete();
    end
  endtask

  // Beats use wd/ws; wl_mask bit i is WLAST for beat i. Model updates on each W handshake.
  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                          input logic [15:0] wl_mask, input bit drain);
    bexp_t e;
    bit ok, good;
    logic [AW-1:0] w;
    good = 1'b1;
    for (int i = 0; i <= len; i++) if (wl_mask[i] != (i == len)) good = 1'b0;
    e.id = id;
    e.resp = good ? 2'b00 : 2'b10;
    b_q.push_back(e);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'd4; awburst = 2'b01; awvalid = 1'b1;
    handshake(0, ok);
    awvalid = 1'b0;
    if (!ok) fail_now("aw_handshake");
    w = addr[AW+3:4];
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wl_mask[i]; wvalid = 1'b1;
      handshake(1, ok);
      if (!ok) fail_now("w_handshake");
      for (int b = 0; b < DW/8; b++) if (ws[i][b]) model_mem[w][b*8 +: 8] = wd[i][b*8 +: 8];
      w = w + 10'd1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    if (drain) drain_b();
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                         input bit drain);
    rexp_t e;
    bit ok;
    logic [AW-1:0] w;
    w = addr[AW+3:4];
    for (int i = 0; i <= len; i++) begin
      e.id = id; e.data = model_mem[w]; e.last = (i == len);
      r_q.push_back(e);
      w = w + 10'd1;
    end
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
    handshake(2, ok);
    arvalid = 1'b0;
    if (!ok) fail_now("ar_handshake");
    if (drain) drain_r();
  endtask

  initial begin
    int n, len;
    logic [31:0] addr;
    logic [15:0] mask;
    aresetn = 1'b0; bready = 1'b1; rready = 1'b1;
    awid = '0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    arid = '0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
    repeat (3) cyc();

    check("rst_awready", DW'(awready), DW'(1'b0));
    check("rst_arready", DW'(arready), DW'(1'b0));
    check("rst_wready", DW'(wready), DW'(1'b0));
    check("rst_bvalid", DW'(bvalid), DW'(1'b0));
    check("rst_rvalid", DW'(rvalid), DW'(1'b0));
    check("rst_rlast", DW'(rlast), DW'(1'b0));
    check("rst_bresp", DW'(bresp), DW'(2'b00));
    check("rst_rresp", DW'(rresp), DW'(2'b00));
    check("rst_bid", DW'(bid), DW'(1'b0));
    check("rst_rid", DW'(rid), DW'(1'b0));
    aresetn = 1'b1;
    check("rel_awready_low", DW'(awready), DW'(1'b0));
    cyc();
    check("rel_awready", DW'(awready), DW'(1'b1));
    check("rel_arready", DW'(arready), DW'(1'b1));

    // Fill the whole array so every later read has a defined expectation.
    for (int blk = 0; blk < DEPTH/16; blk++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        ws[i] = 16'hFFFF;
      end
      do_write(1'b0, 32'(blk * 256), 15, 16'h8000, 1'b1);
    end

    for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); ws[i] = 16'hFFFF; end
    do_write(1'b1, 32'h100, 3, 16'h0008, 1'b1);
    do_read(1'b0, 32'h100, 3, 1'b1);
    do_read(1'b1, 32'h0000_4100, 3, 1'b1);

    wd[0] = {DW{1'b1}}; ws[0] = 16'hFFFF;
    do_write(1'b0, 32'h0, 0, 16'h0001, 1'b1);
    wd[0] = {DW{1'b0}}; ws[0] = 16'h0001;
    do_write(1'b1, 32'h0, 0, 16'h0001, 1'b1);
    do_read(1'b1, 32'h0, 0, 1'b1);

    wd[0] = {4{32'hA5A5_0001}}; wd[1] = {4{32'h5A5A_0002}}; ws[0] = 16'hFFFF; ws[1] = 16'hFFFF;
    do_write(1'b1, 32'h3FF0, 1, 16'h0002, 1'b1);
    do_read(1'b0, 32'h3FF0, 1, 1'b1);
    do_read(1'b1, 32'h0, 0, 1'b1);

    wd[0] = {4{32'h1111_2222}}; wd[1] = {4{32'h3333_4444}};
    do_write(1'b0, 32'h200, 1, 16'h0001, 1'b1);
    do_read(1'b0, 32'h200, 1, 1'b1);

    bready = 1'b0;
    for (int i = 0; i < 3; i++) begin wd[i] = {$urandom(), $urandom(), $urandom(), $urandom()}; ws[i] = 16'hFFFF; end
    do_write(1'b1, 32'h300, 2, 16'h0004, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("bstall_bvalid", DW'(bvalid), DW'(1'b1));
      check("bstall_bresp", DW'(bresp), DW'(b_q[0].resp));
      check("bstall_bid", DW'(bid), DW'(b_q[0].id));
      check("bstall_awready", DW'(awready), DW'(1'b0));
      cyc();
    end
    bready = 1'b1;
    drain_b();

    rready = 1'b0;
    do_read(1'b1, 32'h300, 2, 1'b0);
    n = 0;
    while (!rvalid && n < 20) begin cyc(); n++; end
    if (!rvalid) fail_now("rstall_wait");
    for (int k = 0; k < 5; k++) begin
      check("rstall_rvalid", DW'(rvalid), DW'(1'b1));
      check("rstall_rdata", rdata, r_q[0].data);
      check("rstall_rlast", DW'(rlast), DW'(r_q[0].last));
      cyc();
    end
    drain_r();

    // Abort a LEN=7 read while beat 2 is presented.
    do_read(1'b1, 32'h500, 7, 1'b0);
    rready = 1'b1;
    n = 0;
    while (!(r_q.size() == 7 && rvalid) && n < 50) begin cyc(); n++; end
    if (!(r_q.size() == 7 && rvalid)) fail_now("beat2_wait");
    aresetn = 1'b0;
    cyc();
    check("abort_rvalid", DW'(rvalid), DW'(1'b0));
    check("abort_rlast", DW'(rlast), DW'(1'b0));
    check("abort_arready", DW'(arready), DW'(1'b0));
    r_q.delete();
    aresetn = 1'b1;
    cyc();
    check("abort_arready_rise", DW'(arready), DW'(1'b1));
    do_read(1'b0, 32'h500, 7, 1'b1);

    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      len  = $urandom_range(0, 15);
      addr = $urandom();
      for (int i = 0; i < 16; i++) begin
        wd[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        ws[i] = 16'($urandom());
      end
      mask = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : (16'd1 << len);
      do_write(1'($urandom_range(0, 1)), addr, len, mask, 1'b1);
      if ($urandom_range(0, 1) == 1) do_read(1'($urandom_range(0, 1)), addr, len, 1'b1);
      else do_read(1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 15), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: AXI data bus width in bits.
REQ-002 SHALL have parameter MEM_AWIDTH, default 10: log2 of the memory depth in DATA_WIDTH-bit words.
REQ-003 SHALL have parameter ID_WIDTH, default 1: AXI ID width.
REQ-004 ACLK  in  1  single clock; every flop in the block SHALL be clocked by its rising edge.
REQ-005 ARESETN  in  1  reset, synchronous and active-low.
REQ-006 S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  ID_WIDTH/32/8/3/2/1  write address channel; AWREADY  out  1.
REQ-007 S_AXI_WDATA/WSTRB/WLAST/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel; WREADY  out  1.
REQ-008 S_AXI_BID/BRESP/BVALID  out  ID_WIDTH/2/1  write response channel; BREADY  in  1.
REQ-009 S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID_WIDTH/32/8/3/2/1  read address channel; ARREADY  out  1.
REQ-010 S_AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel; RREADY  in  1.

Function
REQ-011 Storage SHALL be a 2^MEM_AWIDTH x DATA_WIDTH array with one write port and one registered read port; word index = ADDR[MEM_AWIDTH+3:4]; higher address bits ignored (aliasing).
REQ-012 AxSIZE and AxBURST SHALL be ignored; every burst is INCR of full-width beats, AxLEN+1 beats.
REQ-013 Word index SHALL increment by 1 per beat and wrap modulo 2^MEM_AWIDTH.
REQ-014 Write FSM states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE; AW handshake latches AWID, word index, AWLEN, clears beat count, goes W_DATA.
REQ-015 In W_DATA WREADY=1; each W handshake writes byte lanes where WSTRB=1 and increments beat count; the beat with count==AWLEN goes W_RESP.
REQ-016 BRESP SHALL be 2'b00 if WLAST was high exactly on the final beat, else 2'b10 (SLVERR); data is written regardless.
REQ-017 In W_RESP BVALID=1, BID=latched AWID, held stable until BREADY; handshake returns to W_IDLE.
REQ-018 Read FSM states R_IDLE, R_FETCH, R_DATA; ARREADY=1 only in R_IDLE; AR handshake latches ARID, word index, ARLEN, goes R_FETCH.
REQ-019 R_FETCH SHALL issue one array read, go R_DATA next cycle; R_DATA drives RVALID=1, RDATA, RRESP=2'b00, RID=latched ARID, RLAST=1 on beat ARLEN.
REQ-020 R outputs SHALL hold stable while RVALID=1 and RREADY=0; handshake on last beat -> R_IDLE, else -> R_FETCH (throughput 1 beat / 2 cycles).
REQ-021 Read and write FSMs SHALL run independently and concurrently; one outstanding transaction per direction.
REQ-022 Same-cycle write and read of the same word SHALL return old data (read-first).

Reset
REQ-023 While ARESETN=0 at a clock edge: both FSMs to IDLE, AWREADY=ARREADY=WREADY=BVALID=RVALID=RLAST=0, BRESP=RRESP=0, BID=RID=0, counters 0.
REQ-024 AWREADY and ARREADY SHALL rise the first cycle after ARESETN=1.
REQ-025 Reset mid-burst SHALL abort the burst with no response; memory contents are not reset, beats already written persist.

Structure
REQ-026 FSM state encodings and the OKAY/SLVERR BRESP constants SHALL live in shared package axi_pkg.
REQ-027 The storage array SHALL be a sub-module axi_slave_ram (simple dual-port, byte-enable write, registered read).

Verification
REQ-028 AW addr 0x100, LEN=3, data 1..4, WSTRB all-ones, WLAST on beat 4 -> BVALID, BRESP=00, BID=AWID; AR 0x100 LEN=3 -> RDATA 1,2,3,4, RLAST only on 4th.
REQ-029 Write 0xFF..FF to word 0, then write 0x00.. with WSTRB=0x0001 -> read word 0 = 0xFF..FF00.
REQ-030 AW addr 0x3FF0 (word 1023, MEM_AWIDTH=10), LEN=1, data A,B -> word 1023=A, word 0=B.
REQ-031 LEN=1 write with WLAST on beat 1 only -> BRESP=10, both beats still written.
REQ-032 Read with RREADY=0 for 5 cycles -> RVALID, RDATA, RLAST stable throughout; BREADY held low -> BVALID stable, AWREADY=0.
REQ-033 ARESETN=0 during beat 2 of LEN=7 read -> next cycle RVALID=0, ARREADY=1 one cycle after release; new read completes normally.
